ie_stack_seq: RTL and testbench
===============================

Name: ie_stack_seq

Overview:
- Parametrised stack-page sequencer for the instruction-execute stage.
- Performs multi-byte pushes and pulls for JSR/RTS (2 bytes) and BRK/IRQ/RTI (3 bytes) as a single request, replacing the per-byte push and pull sequencing.
- Owns the stack pointer and drives the IE memory bus while busy.
- Supports arbitrary byte counts up to MAX_BYTES and a configurable memory read latency.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- SP_W, 8, stack pointer width; must be ≤ ADDR_W.
- STACK_PAGE, 8'h01, upper address bits; mem_addr = {STACK_PAGE, sp}, width ADDR_W-SP_W.
- MAX_BYTES, 4, maximum bytes per request.
- RD_LAT, 2, clock edges from the edge that drives a read address to the edge that samples mem_data_in; must be ≥ 1.
- SP_RESET, 8'hFD, stack pointer value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only in IDLE.
- op  in  1  0 = push, 1 = pull.
- count  in  CW  bytes to transfer, CW = $clog2(MAX_BYTES+1).
- push_data  in  MAX_BYTES*DATA_W  packed push bytes; byte i = bits [i*DATA_W +: DATA_W].
- pull_data  out  MAX_BYTES*DATA_W  packed pulled bytes, same layout.
- busy  out  1  high from the cycle after an accepted start until the done cycle.
- done  out  1  one-cycle completion pulse.
- sp  out  SP_W  current stack pointer.
- sp_load  in  1  load sp from sp_load_val.
- sp_load_val  in  SP_W  value for sp_load (TXS).
- mem_addr  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  write data.
- mem_data_in  in  DATA_W  read data.
- mem_write_en  out  1  write strobe.
- wrap_err  out  1  present only with IE_STACK_WRAP_DETECT_EN.

Behaviour:
- Reset (async, rst low):
  - State = IDLE, sp = SP_RESET.
  - busy, done, mem_write_en = 0; mem_addr, mem_data_out, pull_data = 0.
  - Reset mid-operation aborts immediately; no further writes.
- All outputs are registered.
- States: IDLE, PUSH, PULL_WAIT, DONE.
- IDLE:
  - sp_load takes priority: sp <= sp_load_val, and a simultaneous start is dropped.
  - Otherwise start latches op and n = min(count, MAX_BYTES).
  - n = 0: go to DONE, no bus activity.
  - sp_load while busy is ignored.
- PUSH:
  - Bytes go out highest index first (n-1 down to 0), so PC high is pushed before PC low.
  - Each cycle: mem_addr = {STACK_PAGE, sp}, mem_data_out = byte, mem_write_en = 1, sp <= sp-1.
  - First write appears the cycle after start.
  - After n write cycles go to DONE, with mem_write_en = 0 in DONE.
- PULL:
  - Bytes are filled from index 0 upward.
  - For each byte: drive mem_addr = {STACK_PAGE, sp+1} with mem_write_en = 0, and sp <= sp+1 on the same edge.
  - In PULL_WAIT, sample mem_data_in into byte i RD_LAT edges later.
  - The next address is driven on the sampling edge. Reads are not overlapped, so a pull takes n*RD_LAT cycles.
  - Unused pull_data bytes are cleared to 0 at start.
- DONE:
  - done = 1 and busy = 0 for one cycle, then IDLE.
  - A start presented during DONE is ignored.
- Latency from start to done:
  - push: n+1 cycles.
  - pull: n*RD_LAT+1 cycles.
  - n = 0: 1 cycle.
- sp arithmetic is modulo 2^SP_W: push from 0 gives all-ones, pull from all-ones gives 0.
- pull_data holds its value until the next accepted pull.
- Outside an operation: mem_addr holds its last value and mem_write_en = 0.

Optional Feature:
- Macro: IE_STACK_WRAP_DETECT_EN.
- Defined:
  - wrap_err port exists.
  - It is set on the done cycle if any push decremented sp from 0 or any pull incremented sp from all-ones during that request.
  - It clears on the next accepted start or on reset.
  - Wrapping behaviour itself is unchanged.
- Undefined: port and logic are absent; wrapping is silent.

Test Plan:
- Push, n=2: sp=FD, push_data[15:0]=16'h1234, start → cycle1 write 01FD=12, cycle2 write 01FC=34, cycle3 done=1, sp=FB.
- Pull, n=2: sp=FB, memory 01FC=34, 01FD=12, RD_LAT=2 → addr 01FC then 01FE... no: addr 01FC, then 01FD two cycles later; done at cycle 5; pull_data[15:0]=16'h1234; sp=FD.
- Wrap: sp=00, push n=1 data A5 → write 0100=A5, sp=FF, wrap_err=1 with done (macro defined).
- Edge requests: n=0 start → done next cycle, no write, sp unchanged; count=7 with MAX_BYTES=4 → exactly 4 writes.
- Contention: start during busy is ignored; sp_load=1 with start in IDLE → sp=sp_load_val, no operation, no done.
- Reset: rst low during the 2nd byte of a 3-byte push → immediate mem_write_en=0, sp=FD, busy=0, no further writes after release.

Source files
------------

// File: rtl/ie_stack_seq_if.sv
// ie_stack_seq_if: IE memory bus between the stack sequencer (master) and memory (slave).
interface ie_stack_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_en;
    modport master (output mem_addr, mem_data_out, mem_write_en, input mem_data_in);
    modport slave (input mem_addr, mem_data_out, mem_write_en, output mem_data_in);
endinterface

// File: rtl/ie_stack_seq.sv
// ie_stack_seq: multi-byte stack push/pull sequencer owning sp for the IE stage.
// Optional wrap_err output is enabled by defining IE_STACK_WRAP_DETECT_EN.
module ie_stack_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int SP_W = 8,
    parameter logic [ADDR_W-SP_W-1:0] STACK_PAGE = 8'h01,
    parameter int MAX_BYTES = 4,
    parameter int RD_LAT = 2,
    parameter logic [SP_W-1:0] SP_RESET = 8'hFD,
    localparam int CW = $clog2(MAX_BYTES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          op,
    input  logic [CW-1:0]                 count,
    input  logic [MAX_BYTES*DATA_W-1:0]   push_data,
    output logic [MAX_BYTES*DATA_W-1:0]   pull_data,
    output logic                          busy,
    output logic                          done,
    output logic [SP_W-1:0]               sp,
    input  logic                          sp_load,
    input  logic [SP_W-1:0]               sp_load_val,
`ifdef IE_STACK_WRAP_DETECT_EN
    output logic                          wrap_err,
`endif
    ie_stack_seq_if.master                mem
);
    localparam logic [1:0] IDLE = 2'd0, PUSH = 2'd1, PULL_WAIT = 2'd2, DONE = 2'd3;
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BYTES);
    localparam logic [LW-1:0] LAT0 = LW'(RD_LAT - 1);

    logic [1:0] state;
    logic [CW-1:0] n_req, n_r, idx;
    logic [LW-1:0] lat_c;
    logic [MAX_BYTES*DATA_W-1:0] push_r;
    logic [SP_W-1:0] sp_inc, sp_dec;
    logic accept, push_last, pull_smp, pull_last;

    assign n_req = count > MAXB ? MAXB : count;
    assign sp_inc = sp + 1'b1;
    assign sp_dec = sp - 1'b1;
    assign accept = state == IDLE && !sp_load && start;
    assign push_last = state == PUSH && idx == '0;
    assign pull_smp = state == PULL_WAIT && lat_c == '0;
    assign pull_last = pull_smp && idx + 1'b1 == n_r;

    // push: idx counts bytes still to write; pull: idx is the byte being fetched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sp <= SP_RESET;
            busy <= 1'b0;
            done <= 1'b0;
            pull_data <= '0;
            push_r <= '0;
            n_r <= '0;
            idx <= '0;
            lat_c <= '0;
            mem.mem_addr <= '0;
            mem.mem_data_out <= '0;
            mem.mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sp_load) sp <= sp_load_val;
                    else if (accept) begin
                        n_r <= n_req;
                        push_r <= push_data;
                        idx <= '0;
                        lat_c <= LAT0;
                        if (op) pull_data <= '0;
                        if (n_req == '0) begin
                            state <= DONE;
                            done <= 1'b1;
                        end else if (!op) begin
                            state <= PUSH;
                            busy <= 1'b1;
                            mem.mem_addr <= {STACK_PAGE, sp};
                            mem.mem_data_out <= push_data[(n_req - 1'b1)*DATA_W +: DATA_W];
                            mem.mem_write_en <= 1'b1;
                            sp <= sp_dec;
                            idx <= n_req - 1'b1;
                        end else begin
                            state <= PULL_WAIT;
                            busy <= 1'b1;
                            mem.mem_addr <= {STACK_PAGE, sp_inc};
                            sp <= sp_inc;
                        end
                    end
                end
                PUSH: begin
                    if (push_last) begin
                        state <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                        mem.mem_write_en <= 1'b0;
                    end else begin
                        mem.mem_addr <= {STACK_PAGE, sp};
                        mem.mem_data_out <= push_r[(idx - 1'b1)*DATA_W +: DATA_W];
                        sp <= sp_dec;
                        idx <= idx - 1'b1;
                    end
                end
                PULL_WAIT: begin
                    if (!pull_smp) lat_c <= lat_c - 1'b1;
                    else begin
                        pull_data[idx*DATA_W +: DATA_W] <= mem.mem_data_in;
                        if (pull_last) begin
                            state <= DONE;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            mem.mem_addr <= {STACK_PAGE, sp_inc};
                            sp <= sp_inc;
                            idx <= idx + 1'b1;
                            lat_c <= LAT0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end

`ifdef IE_STACK_WRAP_DETECT_EN
    logic wrap_acc, wrap_ev;

    assign wrap_ev = (accept && n_req != '0 && (op ? &sp : sp == '0)) ||
                     (state == PUSH && !push_last && sp == '0) ||
                     (pull_smp && !pull_last && &sp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_acc <= 1'b0;
            wrap_err <= 1'b0;
        end else if (accept) begin
            wrap_acc <= wrap_ev;
            wrap_err <= 1'b0;
        end else begin
            wrap_acc <= wrap_acc | wrap_ev;
            if (push_last || pull_last) wrap_err <= wrap_acc;
        end
    end
`endif
endmodule

// File: tb/tb_ie_stack_seq.sv
// tb_ie_stack_seq: directed tests for ie_stack_seq with a registered-read memory model.
module tb_ie_stack_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, op = 1'b0, sp_load = 1'b0;
    logic [2:0] count = '0;
    logic [31:0] push_data = '0;
    logic [31:0] pull_data;
    logic busy, done;
    logic [7:0] sp;
    logic [7:0] sp_load_val = '0;
`ifdef IE_STACK_WRAP_DETECT_EN
    logic wrap_err;
`endif
    logic [7:0] mem [0:65535];
    logic [7:0] rd_q;
    int wr_cnt = 0;
    int checks = 0;
    int errors = 0;
    int w0;

    ie_stack_seq_if #(.ADDR_W(16), .DATA_W(8)) m ();

    ie_stack_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .count(count),
        .push_data(push_data), .pull_data(pull_data), .busy(busy), .done(done),
        .sp(sp), .sp_load(sp_load), .sp_load_val(sp_load_val),
`ifdef IE_STACK_WRAP_DETECT_EN
        .wrap_err(wrap_err),
`endif
        .mem(m)
    );

    always #5 clk = ~clk;

    // memory returns data for the address seen at edge k on edge k+1, sampled by the DUT at k+2
    always @(posedge clk) begin
        if (m.mem_write_en === 1'b1) begin
            mem[m.mem_addr] <= m.mem_data_out;
            wr_cnt++;
        end
        rd_q <= mem[m.mem_addr];
    end
    assign m.mem_data_in = rd_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (m.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", m.mem_write_en); end
        checks++; if (m.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", m.mem_addr); end
        checks++; if (pull_data !== 32'h0) begin errors++; $display("FAIL reset_pull got %h want 0", pull_data); end
        checks++; if (sp !== 8'hFD) begin errors++; $display("FAIL reset_sp got %h want fd", sp); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_push();
        w0 = wr_cnt;
        push_data = 32'h0000_1234; count = 3'd2; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || m.mem_write_en !== 1'b1) begin errors++; $display("FAIL push_c1_ctl got busy=%b we=%b want 1 1", busy, m.mem_write_en); end
        checks++; if (m.mem_addr !== 16'h01FD || m.mem_data_out !== 8'h12) begin errors++; $display("FAIL push_c1 got %h=%h want 01fd=12", m.mem_addr, m.mem_data_out); end
        tick();
        checks++; if (m.mem_addr !== 16'h01FC || m.mem_data_out !== 8'h34 || m.mem_write_en !== 1'b1) begin errors++; $display("FAIL push_c2 got %h=%h we=%b want 01fc=34 1", m.mem_addr, m.mem_data_out, m.mem_write_en); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL push_c2_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m.mem_write_en !== 1'b0) begin errors++; $display("FAIL push_done got done=%b busy=%b we=%b want 1 0 0", done, busy, m.mem_write_en); end
        checks++; if (sp !== 8'hFB) begin errors++; $display("FAIL push_sp got %h want fb", sp); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL push_done_pulse got %b want 0", done); end
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL push_writes got %0d want 2", wr_cnt - w0); end
        checks++; if (mem[16'h01FD] !== 8'h12 || mem[16'h01FC] !== 8'h34) begin errors++; $display("FAIL push_mem got %h %h want 12 34", mem[16'h01FD], mem[16'h01FC]); end
    endtask

    task automatic test_pull();
        op = 1'b1; count = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (m.mem_addr !== 16'h01FC || m.mem_write_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pull_c1 got %h we=%b busy=%b want 01fc 0 1", m.mem_addr, m.mem_write_en, busy); end
        checks++; if (sp !== 8'hFC) begin errors++; $display("FAIL pull_c1_sp got %h want fc", sp); end
        tick();
        checks++; if (m.mem_addr !== 16'h01FC || done !== 1'b0) begin errors++; $display("FAIL pull_c2 got %h done=%b want 01fc 0", m.mem_addr, done); end
        tick();
        checks++; if (m.mem_addr !== 16'h01FD || sp !== 8'hFD) begin errors++; $display("FAIL pull_c3 got %h sp=%h want 01fd fd", m.mem_addr, sp); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pull_c4_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pull_done got done=%b busy=%b want 1 0", done, busy); end
        checks++; if (pull_data !== 32'h0000_1234) begin errors++; $display("FAIL pull_data got %h want 00001234", pull_data); end
        tick();
    endtask

    task automatic test_wrap();
        sp_load = 1'b1; sp_load_val = 8'h00;
        tick();
        sp_load = 1'b0;
        checks++; if (sp !== 8'h00) begin errors++; $display("FAIL wrap_load got %h want 00", sp); end
        op = 1'b0; count = 3'd1; push_data = 32'h0000_00A5; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (m.mem_addr !== 16'h0100 || m.mem_data_out !== 8'hA5 || sp !== 8'hFF) begin errors++; $display("FAIL wrap_push got %h=%h sp=%h want 0100=a5 ff", m.mem_addr, m.mem_data_out, sp); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_push_done got %b want 1", done); end
`ifdef IE_STACK_WRAP_DETECT_EN
        checks++; if (wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_err_push got %b want 1", wrap_err); end
`endif
        tick();
        op = 1'b1; count = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef IE_STACK_WRAP_DETECT_EN
        checks++; if (wrap_err !== 1'b0) begin errors++; $display("FAIL wrap_err_clear got %b want 0", wrap_err); end
`endif
        checks++; if (m.mem_addr !== 16'h0100 || sp !== 8'h00) begin errors++; $display("FAIL wrap_pull got %h sp=%h want 0100 00", m.mem_addr, sp); end
        tick(); tick();
        checks++; if (done !== 1'b1 || pull_data !== 32'h0000_00A5) begin errors++; $display("FAIL wrap_pull_done got done=%b data=%h want 1 000000a5", done, pull_data); end
`ifdef IE_STACK_WRAP_DETECT_EN
        checks++; if (wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_err_pull got %b want 1", wrap_err); end
`endif
        tick();
    endtask

    task automatic test_edges();
        w0 = wr_cnt;
        op = 1'b0; count = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m.mem_write_en !== 1'b0 || sp !== 8'h00) begin errors++; $display("FAIL zero_done got done=%b busy=%b we=%b sp=%h want 1 0 0 00", done, busy, m.mem_write_en, sp); end
        tick();
        checks++; if (done !== 1'b0 || wr_cnt != w0) begin errors++; $display("FAIL zero_after got done=%b writes=%0d want 0 0", done, wr_cnt - w0); end
        sp_load = 1'b1; sp_load_val = 8'hFD;
        tick();
        sp_load = 1'b0;
        w0 = wr_cnt;
        push_data = 32'hDDCC_BBAA; count = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (m.mem_data_out !== 8'hDD) begin errors++; $display("FAIL clamp_first got %h want dd", m.mem_data_out); end
        tick(); tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clamp_early_done got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1 || sp !== 8'hF9) begin errors++; $display("FAIL clamp_done got done=%b sp=%h want 1 f9", done, sp); end
        checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL clamp_writes got %0d want 4", wr_cnt - w0); end
        checks++; if ({mem[16'h01FD], mem[16'h01FC], mem[16'h01FB], mem[16'h01FA]} !== 32'hDDCC_BBAA) begin errors++; $display("FAIL clamp_mem got %h%h%h%h want ddccbbaa", mem[16'h01FD], mem[16'h01FC], mem[16'h01FB], mem[16'h01FA]); end
        tick();
    endtask

    task automatic test_contention();
        w0 = wr_cnt;
        op = 1'b0; count = 3'd3; push_data = 32'h0066_5544; start = 1'b1;
        tick();
        op = 1'b1; count = 3'd1; sp_load = 1'b1; sp_load_val = 8'h40;
        checks++; if (m.mem_addr !== 16'h01F9 || m.mem_data_out !== 8'h66) begin errors++; $display("FAIL busy_c1 got %h=%h want 01f9=66", m.mem_addr, m.mem_data_out); end
        tick(); tick(); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done got %b want 1", done); end
        tick();
        start = 1'b0; sp_load = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sp !== 8'hF6) begin errors++; $display("FAIL busy_ignore got busy=%b done=%b sp=%h want 0 0 f6", busy, done, sp); end
        checks++; if (wr_cnt - w0 !== 3) begin errors++; $display("FAIL busy_writes got %0d want 3", wr_cnt - w0); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL done_start got busy=%b done=%b want 0 0", busy, done); end
        w0 = wr_cnt;
        op = 1'b0; count = 3'd2; sp_load = 1'b1; sp_load_val = 8'h80; start = 1'b1;
        tick();
        start = 1'b0; sp_load = 1'b0;
        checks++; if (sp !== 8'h80 || busy !== 1'b0 || m.mem_write_en !== 1'b0) begin errors++; $display("FAIL load_prio got sp=%h busy=%b we=%b want 80 0 0", sp, busy, m.mem_write_en); end
        tick(); tick();
        checks++; if (done !== 1'b0 || wr_cnt != w0 || sp !== 8'h80) begin errors++; $display("FAIL load_noop got done=%b writes=%0d sp=%h want 0 0 80", done, wr_cnt - w0, sp); end
    endtask

    task automatic test_reset_mid();
        sp_load = 1'b1; sp_load_val = 8'hFD;
        tick();
        sp_load = 1'b0;
        w0 = wr_cnt;
        op = 1'b0; count = 3'd3; push_data = 32'h0033_2211; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (m.mem_addr !== 16'h01FC || m.mem_write_en !== 1'b1) begin errors++; $display("FAIL mid_c2 got %h we=%b want 01fc 1", m.mem_addr, m.mem_write_en); end
        rst = 1'b0;
        #1;
        checks++; if (m.mem_write_en !== 1'b0 || busy !== 1'b0 || sp !== 8'hFD || m.mem_addr !== 16'h0000) begin errors++; $display("FAIL mid_reset got we=%b busy=%b sp=%h addr=%h want 0 0 fd 0000", m.mem_write_en, busy, sp, m.mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (wr_cnt - w0 !== 1 || busy !== 1'b0 || done !== 1'b0 || sp !== 8'hFD) begin errors++; $display("FAIL mid_after got writes=%0d busy=%b done=%b sp=%h want 1 0 0 fd", wr_cnt - w0, busy, done, sp); end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pull();
        test_wrap();
        test_edges();
        test_contention();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
